// File: rtl/producto_escalar_pkg.sv
// -----------------------------------------------------------------------------
// producto_escalar_pkg
// Shared definitions for the parametrised dot-product family: the control
// state encoding, the default operand/length widths and the rule that sizes
// the accumulator so a maximum-length vector can never overflow it.
// No ports (package).
// -----------------------------------------------------------------------------
package producto_escalar_pkg;

   // Control states of the dot-product sequencer
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_LEN_W  = 8;

   // A full-width product needs 2*dataW bits; summing up to 2^lenW-1 of them
   // needs lenW more bits of headroom.
   function automatic int accWidth(input int dataW, input int lenW);
      return 2 * dataW + lenW;
   endfunction

endpackage

// File: rtl/mult_reg_sd.sv
// -----------------------------------------------------------------------------
// mult_reg_sd
// Registered DATA_W x DATA_W multiplier with signed/unsigned select.
// A shift-and-add combinational core feeds one output register; a valid bit
// travels alongside the product so downstream logic knows when to consume it.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset (clears valid and product)
//   signedMode_i 1 = operands are two's complement
//   valid_i      operands on a_i/b_i are to be multiplied
//   a_i, b_i     operands, DATA_W bits
//   valid_o      product_o holds a fresh product this cycle
//   product_o    full 2*DATA_W-bit product
// -----------------------------------------------------------------------------
module mult_reg_sd #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  signedMode_i,
   input  logic                  valid_i,
   input  logic [DATA_W-1:0]     a_i,
   input  logic [DATA_W-1:0]     b_i,
   output logic                  valid_o,
   output logic [2*DATA_W-1:0]   product_o
);

   localparam int PROD_W = 2 * DATA_W;

   logic [PROD_W-1:0] aExt;
   logic [PROD_W-1:0] bExt;
   logic [PROD_W-1:0] productComb;
   logic [PROD_W-1:0] product_q;
   logic              valid_q;

   // Extending both operands to the product width (sign or zero, depending on
   // mode) and keeping the low PROD_W bits of the shift-and-add sum yields the
   // correct two's-complement product, so one core serves both modes.
   always_comb begin
      aExt        = {{DATA_W{a_i[DATA_W-1] & signedMode_i}}, a_i};
      bExt        = {{DATA_W{b_i[DATA_W-1] & signedMode_i}}, b_i};
      productComb = '0;
      for (int i = 0; i < PROD_W; i++) begin
         if (bExt[i]) begin
            productComb = productComb + (aExt << i);
         end
      end
   end

   // Output register: the product only updates on a valid input so it stays
   // quiet between beats; the valid bit follows the input valid every cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         product_q <= '0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            product_q <= productComb;
         end
      end
   end

   assign valid_o   = valid_q;
   assign product_o = product_q;

endmodule

// File: rtl/producto_escalar_param.sv
// -----------------------------------------------------------------------------
// producto_escalar_param
// Streaming dot product sum(a[i]*b[i]) over a runtime-length vector pair,
// unsigned or two's complement, with valid/ready on input and result.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, len,           begin a vector of len beats (sampled in IDLE only);
//   signed_mode           len and signed_mode are latched on that start
//   in_valid, in_ready    a/b beat handshake
//   a, b                  vector elements, DATA_W bits
//   out_valid, out_ready  result handshake
//   result                ACC_W-bit dot product (held after handshake)
//   busy                  high whenever not IDLE
// -----------------------------------------------------------------------------
module producto_escalar_param
   import producto_escalar_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int ACC_W  = accWidth(DATA_W, LEN_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              signed_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  result,
   output logic              busy
);

   localparam int PROD_W = 2 * DATA_W;

   state_t             state_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt_q;
   logic [LEN_W-1:0]   cnt_d;
   logic               signedMode_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   result_q;
   logic               inReady_q;
   logic               outValid_q;
   logic               busy_q;

   logic               accept;
   logic               lastBeat;
   logic               prodValid;
   logic [PROD_W-1:0]  product;
   logic [ACC_W-1:0]   prodExt;

   // in_ready is registered and only ever high in RUN, so a beat is accepted
   // exactly when the source offers one while we advertise readiness.
   always_comb begin
      accept   = in_valid & inReady_q;
      cnt_d    = cnt_q + LEN_W'(1);
      lastBeat = (cnt_d == len_q);
      prodExt  = {{(ACC_W-PROD_W){product[PROD_W-1] & signedMode_q}}, product};
   end

   mult_reg_sd #(
      .DATA_W (DATA_W)
   ) u_mult (
      .clk          (clk),
      .reset        (reset),
      .signedMode_i (signedMode_q),
      .valid_i      (accept),
      .a_i          (a),
      .b_i          (b),
      .valid_o      (prodValid),
      .product_o    (product)
   );

   // Sequencer, accumulator and registered outputs. The product lands one
   // cycle after its beat, so the accumulator trails acceptance by a stage.
   // DRAIN therefore waits until the multiplier valid bit has cleared, which
   // means the final product has been folded into acc_q, before publishing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         signedMode_q <= 1'b0;
         acc_q        <= '0;
         result_q     <= '0;
         inReady_q    <= 1'b0;
         outValid_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         if (prodValid) begin
            acc_q <= acc_q + prodExt;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  len_q        <= len;
                  signedMode_q <= signed_mode;
                  acc_q        <= '0;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
                  if (len != '0) begin
                     state_q   <= RUN;
                     inReady_q <= 1'b1;
                  end else begin
                     state_q    <= DONE;
                     result_q   <= '0;
                     outValid_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  cnt_q <= cnt_d;
                  if (lastBeat) begin
                     state_q   <= DRAIN;
                     inReady_q <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (!prodValid) begin
                  result_q   <= acc_q;
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign result    = result_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_producto_escalar_param.sv
// -----------------------------------------------------------------------------
// tb_producto_escalar_param
// Directed bench for producto_escalar_param at default widths. Expected
// results come from a behavioural dot-product model and are queued when a
// vector is started, then popped when the DUT raises out_valid.
// -----------------------------------------------------------------------------
module tb_producto_escalar_param;

   localparam int DATA_W = 8;
   localparam int LEN_W  = 8;
   localparam int ACC_W  = 2 * DATA_W + LEN_W;

   logic              clk;
   logic              reset;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              signed_mode;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  result;
   logic              busy;

   logic [DATA_W-1:0] aVec [256];
   logic [DATA_W-1:0] bVec [256];
   logic [ACC_W-1:0]  expQ [$];

   int testsRun  = 0;
   int failCount = 0;

   producto_escalar_param dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .len         (len),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .busy        (busy)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge; inputs driven here are
   // sampled on the following edge and outputs read here are settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Behavioural reference for the first n elements of aVec/bVec
   function automatic logic [ACC_W-1:0] model(input logic sm, input int n);
      longint sum = 0;
      for (int i = 0; i < n; i++) begin
         if (sm) sum += longint'($signed(aVec[i])) * longint'($signed(bVec[i]));
         else    sum += longint'(aVec[i]) * longint'(bVec[i]);
      end
      return sum[ACC_W-1:0];
   endfunction

   // Start a vector, queue its expected result and stream n beats. gapMode 1
   // offers in_valid on every third cycle only. Returns just after the edge
   // that accepted the last beat (or the start edge when n == 0).
   task automatic applyStimulus(input logic sm, input int n, input int gapMode);
      int idx;
      int k;
      expQ.push_back(model(sm, n));
      start       = 1'b1;
      len         = LEN_W'(n);
      signed_mode = sm;
      tick();
      start = 1'b0;
      idx   = 0;
      k     = 0;
      while (idx < n && k < 4000) begin
         in_valid = (gapMode == 0) || (k % 3 == 0);
         a        = aVec[idx];
         b        = bVec[idx];
         if (in_valid && in_ready) idx++;
         tick();
         k++;
      end
      in_valid = 1'b0;
      if (idx < n) checkOutput("beats_accepted", 64'(idx), 64'(n));
   endtask

   // Wait (bounded) for out_valid, check latency in edges and the popped result
   task automatic waitResult(input int expLat);
      int n = 0;
      logic [ACC_W-1:0] expected;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         checkOutput("result_timeout", 64'(out_valid), 64'(1));
      end else begin
         checkOutput("latency", 64'(n), 64'(expLat));
         expected = (expQ.size() > 0) ? expQ.pop_front() : '0;
         checkOutput("result", 64'(result), 64'(expected));
      end
   endtask

   task automatic loadTest1();
      for (int i = 0; i < 4; i++) begin
         aVec[i] = DATA_W'(i + 1);
         bVec[i] = DATA_W'(i + 5);
      end
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      len         = '0;
      signed_mode = 1'b0;
      in_valid    = 1'b0;
      a           = '0;
      b           = '0;
      out_ready   = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_result", 64'(result), 64'(0));

      // Test 1: unsigned len=4 continuous, result 70 two edges after last beat
      loadTest1();
      out_ready = 1'b1;
      applyStimulus(1'b0, 4, 0);
      checkOutput("t1_busy_run", 64'(busy), 64'(1));
      checkOutput("t1_in_ready_drop", 64'(in_ready), 64'(0));
      waitResult(2);
      checkOutput("t1_model_70", 64'(model(1'b0, 4)), 64'd70);
      tick();
      checkOutput("t1_busy_after_hs", 64'(busy), 64'(0));
      checkOutput("t1_out_valid_after_hs", 64'(out_valid), 64'(0));
      checkOutput("t1_result_hold", 64'(result), 64'd70);

      // Test 2: signed and unsigned interpretation of the same bytes
      aVec[0] = 8'hFF; aVec[1] = 8'h02; aVec[2] = 8'hFD;
      bVec[0] = 8'h04; bVec[1] = 8'hFB; bVec[2] = 8'h06;
      applyStimulus(1'b1, 3, 0);
      waitResult(2);
      tick();
      checkOutput("t2_signed_const", 64'(result), 64'hFFFFE0);
      applyStimulus(1'b0, 3, 0);
      waitResult(2);
      tick();
      checkOutput("t2_unsigned_const", 64'(result), 64'd3040);

      // Test 3: maximum length, all operands 255
      for (int i = 0; i < 255; i++) begin
         aVec[i] = 8'hFF;
         bVec[i] = 8'hFF;
      end
      applyStimulus(1'b0, 255, 0);
      waitResult(2);
      tick();
      checkOutput("t3_max_const", 64'(result), 64'hFD02FF);

      // Test 4: gapped in_valid; surplus beats after the last must be ignored
      loadTest1();
      applyStimulus(1'b0, 4, 1);
      in_valid = 1'b1;
      a        = 8'd99;
      b        = 8'd99;
      checkOutput("t4_in_ready_low", 64'(in_ready), 64'(0));
      waitResult(2);
      in_valid = 1'b0;
      tick();
      checkOutput("t4_result_70", 64'(result), 64'd70);

      // Test 5: backpressure in DONE, start ignored, single-cycle handshake
      out_ready = 1'b0;
      applyStimulus(1'b0, 4, 0);
      waitResult(2);
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         len   = 8'd4;
         tick();
         checkOutput("t5_hold_valid", 64'(out_valid), 64'(1));
         checkOutput("t5_hold_result", 64'(result), 64'd70);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      checkOutput("t5_hs_valid", 64'(out_valid), 64'(0));
      checkOutput("t5_hs_busy", 64'(busy), 64'(0));
      tick();
      checkOutput("t5_start_ignored", 64'(busy), 64'(0));
      out_ready = 1'b1;

      // Test 6a: zero-length vector
      applyStimulus(1'b0, 0, 0);
      waitResult(0);
      tick();
      checkOutput("t6_len0_idle", 64'(busy), 64'(0));

      // Test 6b: reset after two accepted beats discards the partial sum
      start = 1'b1;
      len   = 8'd4;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      a        = 8'd7;
      b        = 8'd9;
      tick();
      tick();
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t6_rst_busy", 64'(busy), 64'(0));
      checkOutput("t6_rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("t6_rst_result", 64'(result), 64'(0));
      checkOutput("t6_rst_in_ready", 64'(in_ready), 64'(0));
      loadTest1();
      applyStimulus(1'b0, 4, 0);
      waitResult(2);
      tick();
      checkOutput("t6_rerun_70", 64'(result), 64'd70);
      checkOutput("t6_queue_empty", 64'(expQ.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
